// File: rtl/uart_tx_port_pkg.sv
// Shared constants for the UART transmit port: chip-select windows, FSM
// state encoding and status word bit positions.
package uart_tx_port_pkg;

  localparam logic [3:0] CS_RAM  = 4'b0000;
  localparam logic [3:0] CS_LED  = 4'b0001;
  localparam logic [3:0] CS_SEG  = 4'b0010;
  localparam logic [3:0] CS_UART = 4'b0011;
  localparam logic [3:0] CS_PORT = 4'b0100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_FULL   = 1;
  localparam int STAT_OVF    = 2;
  localparam int STAT_CNT_LO = 3;
  localparam int STAT_CNT_HI = 6;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte queue feeding the serializer. A push into a full queue is still
// accepted when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty,
  output logic       push_ok,
  output logic [3:0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][7:0] mem_q, mem_d;
  logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  pop_ok;

  assign full  = (cnt_q == 4'(DEPTH));
  assign empty = (cnt_q == 4'd0);
  assign count = cnt_q;
  assign rdata = mem_q[rd_q];

  // Power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);
    mem_d   = mem_q;
    if (push_ok) mem_d[wr_q] = wdata;
    wr_d  = wr_q + PW'(push_ok);
    rd_d  = rd_q + PW'(pop_ok);
    cnt_d = cnt_q + 4'(push_ok) - 4'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: stores to the window are queued and
// serialized on tx; a registered status word feeds the read mux.
module uart_tx_port
  import uart_tx_port_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [3:0]  ADDR_SEL     = CS_UART
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        write,
  output logic        status_sel,
  output logic [15:0] status_out,
  output logic        tx
);
  localparam int BW = $clog2(CLKS_PER_BIT);

  tx_state_e   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        ovf_q, ovf_d;
  logic [15:0] status_q, status_d;

  logic       hit, push, clr, pop, bit_end;
  logic [7:0] f_rdata;
  logic       f_full, f_empty, f_push_ok;
  logic [3:0] f_count;
  logic       unused_bits;

  assign hit        = (addr[15:12] == ADDR_SEL) & write;
  assign push       = hit & ~addr[0];
  assign clr        = hit & addr[0];
  assign status_sel = (addr[15:12] == ADDR_SEL) & ~write;
  assign bit_end    = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign unused_bits = ^{data_in[15:8], addr[11:1]};
  assign tx         = tx_q;
  assign status_out = status_q;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (Clock),
    .rst_n  (Resetn),
    .push   (push),
    .pop    (pop),
    .wdata  (data_in[7:0]),
    .rdata  (f_rdata),
    .full   (f_full),
    .empty  (f_empty),
    .push_ok(f_push_ok),
    .count  (f_count)
  );

  // tx is registered from the next-state decision so it changes together
  // with the state it belongs to.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!f_empty) begin
          pop     = 1'b1;
          shift_d = f_rdata;
          state_d = ST_START;
          baud_d  = '0;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end else baud_d = baud_q + BW'(1);
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end else baud_d = baud_q + BW'(1);
      end
      ST_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (!f_empty) begin
            pop     = 1'b1;
            shift_d = f_rdata;
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else baud_d = baud_q + BW'(1);
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (clr)                    ovf_d = 1'b0;
    else if (push & ~f_push_ok) ovf_d = 1'b1;
    status_d                           = '0;
    status_d[STAT_BUSY]                = (state_q != ST_IDLE) | ~f_empty;
    status_d[STAT_FULL]                = f_full;
    status_d[STAT_OVF]                 = ovf_q;
    status_d[STAT_CNT_HI:STAT_CNT_LO]  = f_count;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      ovf_q    <= 1'b0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      ovf_q    <= ovf_d;
      status_q <= status_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port: directed scenarios plus random traffic, checked
// every cycle against a frame-timing reference model.
module tb_uart_tx_port;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic [15:0] addr, data_in;
  logic        write;
  logic        status_sel;
  logic [15:0] status_out;
  logic        tx;

  uart_tx_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .ADDR_SEL(4'b0011)) dut (
    .Clock(Clock), .Resetn(Resetn), .addr(addr), .data_in(data_in),
    .write(write), .status_sel(status_sel), .status_out(status_out), .tx(tx)
  );

  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a byte queue, the cycle of the last pop and the
  // earliest cycle another pop may happen.
  int          cyc = 0;
  logic [7:0]  mq[$];
  int          next_pop_ok = 0;
  bit          have_frame = 0;
  int          frame_p = 0;
  logic [7:0]  frame_byte = 8'h00;
  bit          m_ovf = 0;
  logic [15:0] exp_status = 16'h0;
  logic        tx_log[$];
  logic [15:0] st_log[$];

  function automatic logic exp_tx();
    int i;
    if (have_frame && cyc >= frame_p + 1 && cyc <= frame_p + FRAME) begin
      i = (cyc - frame_p - 1) / CPB;
      if (i == 0) return 1'b0;
      if (i <= 8) return frame_byte[i-1];
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    mq.delete();
    have_frame  = 0;
    m_ovf       = 0;
    exp_status  = 16'h0;
    next_pop_ok = cyc;
  endtask

  task automatic step(input logic w, input logic [15:0] a, input logic [15:0] d);
    int  n;
    bit  pop, busy;
    @(negedge Clock);
    tx_log.push_back(tx);
    st_log.push_back(status_out);
    chk("tx", 32'(tx), 32'(exp_tx()));
    chk("status", 32'(status_out), 32'(exp_status));
    write = w; addr = a; data_in = d;
    #1 chk("status_sel", 32'(status_sel), 32'((a[15:12] == 4'h3) && !w));
    n    = mq.size();
    busy = (have_frame && cyc <= frame_p + FRAME) || n > 0;
    exp_status      = 16'h0;
    exp_status[0]   = busy;
    exp_status[1]   = (n == DEPTH);
    exp_status[2]   = m_ovf;
    exp_status[6:3] = 4'(n);
    pop = (n > 0) && (cyc >= next_pop_ok);
    if (pop) begin
      frame_byte  = mq.pop_front();
      frame_p     = cyc;
      have_frame  = 1;
      next_pop_ok = cyc + FRAME;
    end
    if (w && a[15:12] == 4'h3) begin
      if (!a[0]) begin
        if (n < DEPTH || pop) mq.push_back(d[7:0]);
        else m_ovf = 1;
      end else m_ovf = 0;
    end
    cyc++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Resetn = 1'b0;
    write  = 1'b0;
    #1;
    chk("rst_tx", 32'(tx), 32'h1);
    chk("rst_status", 32'(status_out), 32'h0);
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    model_reset();
  endtask

  logic [9:0] a5_frame;
  int base, guard, pct;
  logic [15:0] s;

  initial begin
    Resetn = 1'b0; write = 1'b0; addr = 16'h0; data_in = 16'h0;
    repeat (3) @(negedge Clock);
    chk("reset_tx", 32'(tx), 32'h1);
    chk("reset_status", 32'(status_out), 32'h0);
    Resetn = 1'b1;
    model_reset();

    // 1: single 0xA5 frame, checked bit by bit against a fixed pattern
    a5_frame = 10'b1_10100101_0;
    base = tx_log.size();
    step(1'b1, 16'h3000, 16'h00A5);
    idle(50);
    chk("t1_pre", 32'(tx_log[base+1]), 32'h1);
    for (int i = 0; i < 10; i++)
      chk("t1_bit", 32'(tx_log[base + 2 + CPB*i + 1]), 32'(a5_frame[i]));
    chk("t1_busy", 32'(st_log[base+20][0]), 32'h1);
    chk("t1_busy_last", 32'(st_log[base+42][0]), 32'h1);
    chk("t1_idle", 32'(st_log[base+43][0]), 32'h0);

    // 2: back-to-back frames, no idle gap
    base = tx_log.size();
    step(1'b1, 16'h3000, 16'h0011);
    step(1'b1, 16'h3000, 16'h0022);
    step(1'b1, 16'h3000, 16'h0033);
    idle(130);
    chk("t2_stop1", 32'(tx_log[base+41]), 32'h1);
    chk("t2_start2", 32'(tx_log[base+42]), 32'h0);
    chk("t2_start3", 32'(tx_log[base+82]), 32'h0);
    chk("t2_cnt", 32'(st_log[base+43][6:3]), 32'h1);

    // 3: overflow on the sixth of six rapid stores
    base = tx_log.size();
    for (int i = 0; i < 6; i++) step(1'b1, 16'h3000, 16'($urandom_range(0, 255)));
    idle(2);
    s = st_log[base+7];
    chk("t3_full", 32'(s[1]), 32'h1);
    chk("t3_ovf", 32'(s[2]), 32'h1);
    chk("t3_cnt", 32'(s[6:3]), 32'h4);

    // 4: clearing overflow does not push
    step(1'b1, 16'h3001, 16'h00FF);
    idle(2);
    s = st_log[st_log.size()-1];
    chk("t4_ovf", 32'(s[2]), 32'h0);
    chk("t4_cnt", 32'(s[6:3]), 32'h4);

    // 5: push into a full queue exactly on the STOP->START pop
    guard = 0;
    while (mq.size() != 3 && guard < 200) begin idle(1); guard++; end
    chk("t5_wait3", 32'(guard < 200), 32'h1);
    step(1'b1, 16'h3000, 16'h0077);
    guard = 0;
    while (cyc != next_pop_ok && guard < 200) begin idle(1); guard++; end
    chk("t5_waitpop", 32'(guard < 200), 32'h1);
    step(1'b1, 16'h3000, 16'h0088);
    idle(2);
    s = st_log[st_log.size()-1];
    chk("t5_ovf", 32'(s[2]), 32'h0);
    chk("t5_cnt", 32'(s[6:3]), 32'h4);
    idle(250);

    // 6: reset in the middle of the data bits of a 0x00 frame
    step(1'b1, 16'h3000, 16'h0000);
    idle(12);
    chk("t6_low", 32'(tx), 32'h0);
    do_reset();
    base = tx_log.size();
    step(1'b1, 16'h3000, 16'h005A);
    idle(50);
    chk("t6_start", 32'(tx_log[base+3]), 32'h0);
    chk("t6_b1", 32'(tx_log[base+2+CPB*2+1]), 32'h1);
    chk("t6_stop", 32'(tx_log[base+2+CPB*9+1]), 32'h1);

    // Random traffic with varying store density
    for (int blk = 0; blk < 12; blk++) begin
      pct = $urandom_range(2, 40);
      for (int i = 0; i < 200; i++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < pct)
          step(1'b1, {4'h3, 12'($urandom_range(0, 4095)) & 12'hFFE}, 16'($urandom()));
        else if (r < pct + 2)
          step(1'b1, 16'h3001, 16'($urandom()));
        else if (r < pct + 6)
          step(1'b1, {4'($urandom_range(0, 2)), 12'($urandom())}, 16'($urandom()));
        else if (r < pct + 10)
          step(1'b0, {4'h3, 12'($urandom())}, 16'h0);
        else
          idle(1);
      end
    end
    idle(400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
